// File: rtl/bp_me_io_cmd_arbiter.sv
// bp_me_io_cmd_arbiter
//
// Merges num_src_p I/O command sources onto one downstream command port and
// routes each downstream response back to the source whose command it answers.
// Responses return in order, so a FIFO of source IDs (one entry per in-flight
// command) is enough to steer them.
//
// Ports
//   clk_i, reset_i       single clock, synchronous active-high reset
//   src_cmd_i/_v_i       per-source command data (packed, source k at slice k) and valid
//   src_cmd_yumi_o       per-source consume strobe (one-hot or zero)
//   src_resp_o/_v_o      response data (broadcast) and per-source valid (one-hot or zero)
//   src_resp_ready_i     per-source response ready
//   io_cmd_o/_v_o        downstream command and valid
//   io_cmd_yumi_i        downstream consumed the command
//   io_resp_i/_v_i       downstream response and valid
//   io_resp_ready_o      arbiter accepts the downstream response
//   outstanding_o        number of commands in flight
//   error_o              sticky: a response arrived with nothing outstanding
module bp_me_io_cmd_arbiter #(
    parameter int num_src_p         = 2,
    parameter int msg_width_p       = 128,
    parameter int max_outstanding_p = 4,
    parameter int rr_p              = 0,
    localparam int src_id_width_lp  = (num_src_p > 1) ? $clog2(num_src_p) : 1,
    localparam int cnt_width_lp     = $clog2(max_outstanding_p + 1),
    localparam int ptr_width_lp     = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1
) (
    input  logic                             clk_i,
    input  logic                             reset_i,

    input  logic [num_src_p*msg_width_p-1:0] src_cmd_i,
    input  logic [num_src_p-1:0]             src_cmd_v_i,
    output logic [num_src_p-1:0]             src_cmd_yumi_o,

    output logic [msg_width_p-1:0]           src_resp_o,
    output logic [num_src_p-1:0]             src_resp_v_o,
    input  logic [num_src_p-1:0]             src_resp_ready_i,

    output logic [msg_width_p-1:0]           io_cmd_o,
    output logic                             io_cmd_v_o,
    input  logic                             io_cmd_yumi_i,

    input  logic [msg_width_p-1:0]           io_resp_i,
    input  logic                             io_resp_v_i,
    output logic                             io_resp_ready_o,

    output logic [cnt_width_lp-1:0]          outstanding_o,
    output logic                             error_o
);

    localparam logic [src_id_width_lp:0] num_src_lp = (src_id_width_lp + 1)'(num_src_p);

    logic [src_id_width_lp-1:0] rr_ptr_q, rr_ptr_d;
    logic [ptr_width_lp-1:0]    wr_ptr_q, wr_ptr_d;
    logic [ptr_width_lp-1:0]    rd_ptr_q, rd_ptr_d;
    logic [cnt_width_lp-1:0]    count_q, count_d;
    logic                       error_q, error_d;
    logic [src_id_width_lp-1:0] id_mem_q [max_outstanding_p];
    logic [src_id_width_lp-1:0] id_mem_d [max_outstanding_p];

    logic [num_src_p-1:0]       grant;
    logic [src_id_width_lp-1:0] grant_id;
    logic                       grant_v;
    logic [src_id_width_lp:0]   search_sum;
    logic [src_id_width_lp-1:0] search_idx;
    logic [src_id_width_lp-1:0] head_id;
    logic                       full, empty, push, pop, orphan;

    function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
        if (p == ptr_width_lp'(max_outstanding_p - 1)) return '0;
        else                                           return p + 1'b1;
    endfunction

    assign full    = (count_q == cnt_width_lp'(max_outstanding_p));
    assign empty   = (count_q == '0);
    assign head_id = id_mem_q[rd_ptr_q];

    // Grant search. Fixed mode scans from index 0; round-robin scans from
    // rr_ptr_q and wraps. Nothing is granted while full or in reset.
    always_comb begin
        grant      = '0;
        grant_id   = '0;
        grant_v    = 1'b0;
        search_sum = '0;
        search_idx = '0;
        if (!reset_i && !full) begin
            for (int i = 0; i < num_src_p; i++) begin
                if (rr_p != 0) begin
                    search_sum = {1'b0, rr_ptr_q} + (src_id_width_lp + 1)'(i);
                    if (search_sum >= num_src_lp) search_sum = search_sum - num_src_lp;
                end else begin
                    search_sum = (src_id_width_lp + 1)'(i);
                end
                search_idx = search_sum[src_id_width_lp-1:0];
                if (!grant_v && src_cmd_v_i[search_idx]) begin
                    grant_v  = 1'b1;
                    grant_id = search_idx;
                end
            end
            if (grant_v) grant[grant_id] = 1'b1;
        end
    end

    // Command path: pure AND-OR mux, no register.
    always_comb begin
        io_cmd_o = '0;
        for (int k = 0; k < num_src_p; k++) begin
            if (grant[k]) io_cmd_o = src_cmd_i[k*msg_width_p +: msg_width_p];
        end
    end

    assign io_cmd_v_o     = grant_v;
    assign src_cmd_yumi_o = grant & {num_src_p{io_cmd_yumi_i}};
    assign push           = grant_v & io_cmd_yumi_i;

    // Response path: steer to the FIFO head; with nothing outstanding, drain
    // the response and flag it.
    always_comb begin
        src_resp_v_o    = '0;
        io_resp_ready_o = 1'b1;
        if (!empty) begin
            io_resp_ready_o = src_resp_ready_i[head_id];
            if (!reset_i) src_resp_v_o[head_id] = io_resp_v_i;
        end
    end

    assign src_resp_o = io_resp_i;
    assign pop        = !empty & io_resp_v_i & io_resp_ready_o;
    assign orphan     = empty & io_resp_v_i;

    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        error_d  = error_q | orphan;
        rr_ptr_d = rr_ptr_q;
        if (rr_p != 0 && push) begin
            if (grant_id == src_id_width_lp'(num_src_p - 1)) rr_ptr_d = '0;
            else                                             rr_ptr_d = grant_id + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        id_mem_d = id_mem_q;
        if (push) id_mem_d[wr_ptr_q] = grant_id;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rr_ptr_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            error_q  <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            error_q  <= error_d;
        end
    end

    // ID storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk_i) begin
        id_mem_q <= id_mem_d;
    end

    assign outstanding_o = count_q;
    assign error_o       = error_q;

    a_grant_onehot: assert property (@(posedge clk_i) disable iff (reset_i) $onehot0(grant));
    a_no_push_full: assert property (@(posedge clk_i) disable iff (reset_i) !(push && full));
    a_src_v_stable: assert property (@(posedge clk_i) disable iff (reset_i)
        $past(reset_i) || ((($past(src_cmd_v_i) & ~$past(src_cmd_yumi_o)) & ~src_cmd_v_i) == '0));

endmodule

// File: tb/tb_bp_me_io_cmd_arbiter.sv
module tb_bp_me_io_cmd_arbiter;

    localparam int W = 16;

    typedef struct packed {
        logic [1:0]   src;
        logic [W-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    exp_t exp_a_cmd[$];
    exp_t exp_a_resp[$];
    exp_t exp_b_cmd[$];

    // Instance A: fixed priority, two sources, four outstanding
    logic           a_rst = 1'b1;
    logic [2*W-1:0] a_cmd = '0;
    logic [1:0]     a_cmd_v = '0;
    logic [1:0]     a_yumi_o;
    logic [W-1:0]   a_resp;
    logic [1:0]     a_resp_v_o;
    logic [1:0]     a_resp_rdy = '0;
    logic [W-1:0]   a_io_cmd;
    logic           a_io_cmd_v;
    logic           a_io_yumi = 1'b0;
    logic [W-1:0]   a_io_resp = '0;
    logic           a_io_resp_v = 1'b0;
    logic           a_io_resp_rdy;
    logic [2:0]     a_out;
    logic           a_err;

    bp_me_io_cmd_arbiter #(.num_src_p(2), .msg_width_p(W), .max_outstanding_p(4), .rr_p(0)) u_fix (
        .clk_i(clk), .reset_i(a_rst),
        .src_cmd_i(a_cmd), .src_cmd_v_i(a_cmd_v), .src_cmd_yumi_o(a_yumi_o),
        .src_resp_o(a_resp), .src_resp_v_o(a_resp_v_o), .src_resp_ready_i(a_resp_rdy),
        .io_cmd_o(a_io_cmd), .io_cmd_v_o(a_io_cmd_v), .io_cmd_yumi_i(a_io_yumi),
        .io_resp_i(a_io_resp), .io_resp_v_i(a_io_resp_v), .io_resp_ready_o(a_io_resp_rdy),
        .outstanding_o(a_out), .error_o(a_err)
    );

    // Instance B: round-robin, three sources, four outstanding
    logic           b_rst = 1'b1;
    logic [3*W-1:0] b_cmd = '0;
    logic [2:0]     b_cmd_v = '0;
    logic [2:0]     b_yumi_o;
    logic [W-1:0]   b_resp;
    logic [2:0]     b_resp_v_o;
    logic [2:0]     b_resp_rdy = '0;
    logic [W-1:0]   b_io_cmd;
    logic           b_io_cmd_v;
    logic           b_io_yumi = 1'b0;
    logic [W-1:0]   b_io_resp = '0;
    logic           b_io_resp_v = 1'b0;
    logic           b_io_resp_rdy;
    logic [2:0]     b_out;
    logic           b_err;

    bp_me_io_cmd_arbiter #(.num_src_p(3), .msg_width_p(W), .max_outstanding_p(4), .rr_p(1)) u_rr (
        .clk_i(clk), .reset_i(b_rst),
        .src_cmd_i(b_cmd), .src_cmd_v_i(b_cmd_v), .src_cmd_yumi_o(b_yumi_o),
        .src_resp_o(b_resp), .src_resp_v_o(b_resp_v_o), .src_resp_ready_i(b_resp_rdy),
        .io_cmd_o(b_io_cmd), .io_cmd_v_o(b_io_cmd_v), .io_cmd_yumi_i(b_io_yumi),
        .io_resp_i(b_io_resp), .io_resp_v_i(b_io_resp_v), .io_resp_ready_o(b_io_resp_rdy),
        .outstanding_o(b_out), .error_o(b_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor A: pops the scoreboard on every command or response handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!a_rst) begin
            if (a_io_cmd_v && a_io_yumi) begin
                if (exp_a_cmd.size() == 0) begin
                    chk("a_cmd_unexpected", {16'h0, a_io_cmd}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_a_cmd.pop_front();
                    chk("a_cmd_yumi", {30'h0, a_yumi_o}, {30'h0, 2'(2'b01 << e.src)});
                    chk("a_cmd_data", {16'h0, a_io_cmd}, {16'h0, e.data});
                end
            end else begin
                chk("a_yumi_idle", {30'h0, a_yumi_o}, 32'h0);
            end
            if (|(a_resp_v_o & a_resp_rdy)) begin
                if (exp_a_resp.size() == 0) begin
                    chk("a_resp_unexpected", {16'h0, a_resp}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_a_resp.pop_front();
                    chk("a_resp_dest", {30'h0, a_resp_v_o}, {30'h0, 2'(2'b01 << e.src)});
                    chk("a_resp_data", {16'h0, a_resp}, {16'h0, e.data});
                end
            end
        end
    end

    // Monitor B
    always @(negedge clk) begin
        exp_t e;
        if (!b_rst && b_io_cmd_v && b_io_yumi) begin
            if (exp_b_cmd.size() == 0) begin
                chk("b_cmd_unexpected", {16'h0, b_io_cmd}, 32'hFFFF_FFFF);
            end else begin
                e = exp_b_cmd.pop_front();
                chk("b_cmd_yumi", {29'h0, b_yumi_o}, {29'h0, 3'(3'b001 << e.src)});
                chk("b_cmd_data", {16'h0, b_io_cmd}, {16'h0, e.data});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]   srcs [3];
        logic [W-1:0] dats [3];
        srcs = '{2'd1, 2'd0, 2'd1};
        dats = '{16'h2001, 16'h1002, 16'h2003};

        // Reset
        tick();
        tick();
        a_rst = 1'b0;
        b_rst = 1'b0;
        chk("rst_a_out", {29'h0, a_out}, 32'd0);
        chk("rst_a_err", {31'h0, a_err}, 32'd0);
        chk("rst_b_out", {29'h0, b_out}, 32'd0);
        tick();

        // Fixed priority: source 0 wins every cycle, source 1 starves
        a_cmd      = {16'h2000, 16'h1000};
        a_cmd_v    = 2'b11;
        a_io_yumi  = 1'b1;
        a_resp_rdy = 2'b11;
        for (int i = 0; i < 4; i++) begin
            exp_a_cmd.push_back('{src: 2'd0, data: 16'h1000});
            #1;
            chk("fix_grant", {30'h0, a_yumi_o}, 32'h1);
            tick();
            chk("fix_count", {29'h0, a_out}, 32'(i + 1));
        end

        // Full: no grant while a source is valid
        #1;
        chk("full_cmd_v", {31'h0, a_io_cmd_v}, 32'd0);
        tick();
        chk("full_count", {29'h0, a_out}, 32'd4);

        // Pop and new command in the same cycle: pop only
        a_io_resp_v = 1'b1;
        a_io_resp   = 16'h00A1;
        exp_a_resp.push_back('{src: 2'd0, data: 16'h00A1});
        #1;
        chk("pop_no_bypass", {31'h0, a_io_cmd_v}, 32'd0);
        chk("pop_ready", {31'h0, a_io_resp_rdy}, 32'd1);
        tick();
        chk("pop_count", {29'h0, a_out}, 32'd3);
        a_io_resp_v = 1'b0;
        exp_a_cmd.push_back('{src: 2'd0, data: 16'h1000});
        #1;
        chk("push_after_pop_v", {31'h0, a_io_cmd_v}, 32'd1);
        tick();
        chk("push_after_pop_cnt", {29'h0, a_out}, 32'd4);

        // Reset: outputs gated while asserted
        a_rst   = 1'b1;
        a_cmd_v = 2'b01;
        #1;
        chk("rst_gate_cmd_v", {31'h0, a_io_cmd_v}, 32'd0);
        chk("rst_gate_yumi", {30'h0, a_yumi_o}, 32'd0);
        tick();
        a_cmd_v   = 2'b00;
        a_io_yumi = 1'b0;
        tick();
        a_rst = 1'b0;
        chk("rst2_count", {29'h0, a_out}, 32'd0);

        // Ordered routing: src1, src0, src1
        a_io_yumi = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_cmd_v = 2'(2'b01 << srcs[i]);
            a_cmd[srcs[i]*W +: W] = dats[i];
            exp_a_cmd.push_back('{src: srcs[i], data: dats[i]});
            tick();
        end
        a_cmd_v   = 2'b00;
        a_io_yumi = 1'b0;
        chk("route_count", {29'h0, a_out}, 32'd3);

        // Backpressure from src1 holds the head
        a_io_resp_v = 1'b1;
        a_io_resp   = 16'h000A;
        a_resp_rdy  = 2'b01;
        #1;
        chk("bp_ready", {31'h0, a_io_resp_rdy}, 32'd0);
        chk("bp_dest", {30'h0, a_resp_v_o}, 32'h2);
        tick();
        chk("bp_count", {29'h0, a_out}, 32'd3);
        a_resp_rdy = 2'b11;
        exp_a_resp.push_back('{src: 2'd1, data: 16'h000A});
        tick();
        a_io_resp = 16'h000B;
        exp_a_resp.push_back('{src: 2'd0, data: 16'h000B});
        tick();
        a_io_resp = 16'h000C;
        exp_a_resp.push_back('{src: 2'd1, data: 16'h000C});
        tick();
        a_io_resp_v = 1'b0;
        chk("route_drained", {29'h0, a_out}, 32'd0);

        // Orphan response
        a_resp_rdy  = 2'b00;
        a_io_resp_v = 1'b1;
        a_io_resp   = 16'h0EEE;
        #1;
        chk("orphan_ready", {31'h0, a_io_resp_rdy}, 32'd1);
        chk("orphan_resp_v", {30'h0, a_resp_v_o}, 32'd0);
        chk("orphan_err_pre", {31'h0, a_err}, 32'd0);
        tick();
        a_io_resp_v = 1'b0;
        chk("orphan_err", {31'h0, a_err}, 32'd1);
        tick();
        chk("orphan_err_held", {31'h0, a_err}, 32'd1);

        // Reset with two outstanding
        a_cmd[W-1:0] = 16'h1004;
        a_cmd_v      = 2'b01;
        a_io_yumi    = 1'b1;
        for (int i = 0; i < 2; i++) begin
            exp_a_cmd.push_back('{src: 2'd0, data: 16'h1004});
            tick();
        end
        a_cmd_v   = 2'b00;
        a_io_yumi = 1'b0;
        chk("pre_rst_count", {29'h0, a_out}, 32'd2);
        a_rst = 1'b1;
        tick();
        a_rst = 1'b0;
        chk("post_rst_count", {29'h0, a_out}, 32'd0);
        chk("post_rst_err", {31'h0, a_err}, 32'd0);

        // Late response after reset is an orphan
        a_resp_rdy  = 2'b11;
        a_io_resp_v = 1'b1;
        a_io_resp   = 16'h0DDD;
        tick();
        a_io_resp_v = 1'b0;
        chk("late_resp_err", {31'h0, a_err}, 32'd1);

        // Round-robin: grants 0,1,2,0
        b_cmd     = {16'h3002, 16'h3001, 16'h3000};
        b_cmd_v   = 3'b111;
        b_io_yumi = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_b_cmd.push_back('{src: 2'(i % 3), data: 16'h3000 + 16'(i % 3)});
            tick();
            chk("rr_count", {29'h0, b_out}, 32'(i + 1));
        end
        b_io_yumi = 1'b0;
        #1;
        chk("rr_full_cmd_v", {31'h0, b_io_cmd_v}, 32'd0);

        tick();
        tick();
        chk("a_cmd_q_empty", 32'(exp_a_cmd.size()), 32'd0);
        chk("a_resp_q_empty", 32'(exp_a_resp.size()), 32'd0);
        chk("b_cmd_q_empty", 32'(exp_b_cmd.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bp_me_io_cmd_arbiter.md
# bp_me_io_cmd_arbiter

Parametrised N-to-1 arbiter and response router for I/O command channels in nonsynth testbenches. It merges `num_src_p` command sources onto a single downstream I/O command port, such as a config loader, an NBF loader and a debug injector. It returns each response to the source that issued the matching command, and sequencing between sources needs no external handshake. The arbitration mode is selectable (fixed priority or round-robin). Up to `max_outstanding_p` commands may be in flight, tracked by an internal source-ID FIFO.

## Interface
- `num_src_p`, 2: number of command sources; must be ≥1.
- `msg_width_p`, 128: width of one command/response message (`bp_cce_mem_msg_s` width in system use).
- `max_outstanding_p`, 4: maximum commands issued downstream without a returned response; ≥1.
- `rr_p`, 0: 0 = fixed priority (lowest index wins); 1 = round-robin.
- `src_id_width_lp`, derived: `BSG_SAFE_CLOG2(num_src_p)`.
- `clk_i`  in  1  clock; single clock domain.
- `reset_i`  in  1  synchronous, active-high reset.
- `src_cmd_i`  in  `num_src_p*msg_width_p`  source commands; source k occupies bits [k*msg_width_p +: msg_width_p].
- `src_cmd_v_i`  in  `num_src_p`  per-source command valid; a source holds the command stable until yumi.
- `src_cmd_yumi_o`  out  `num_src_p`  per-source command consumed; one-hot or zero.
- `src_resp_o`  out  `msg_width_p`  response data, broadcast to all sources.
- `src_resp_v_o`  out  `num_src_p`  per-source response valid; one-hot or zero.
- `src_resp_ready_i`  in  `num_src_p`  per-source response ready.
- `io_cmd_o`  out  `msg_width_p`  downstream command.
- `io_cmd_v_o`  out  1  downstream command valid.
- `io_cmd_yumi_i`  in  1  downstream consumed the command this cycle.
- `io_resp_i`  in  `msg_width_p`  downstream response.
- `io_resp_v_i`  in  1  downstream response valid.
- `io_resp_ready_o`  out  1  arbiter accepts the response.
- `outstanding_o`  out  `BSG_WIDTH(max_outstanding_p)`  current in-flight count.
- `error_o`  out  1  sticky: a response arrived with no outstanding command.

## Operation
- **Grant.** The grant is combinational over `src_cmd_v_i`, masked to zero when `outstanding_o == max_outstanding_p`.
  - Fixed mode: the lowest set index wins.
  - Round-robin mode: search starts at `rr_ptr` and wraps modulo `num_src_p`.
- **Command path.**
  - `io_cmd_v_o` = any granted source; `io_cmd_o` = the granted source's command.
  - `src_cmd_yumi_o[g]` = `io_cmd_yumi_i` for the granted source g, and 0 for all others.
  - Commands pass through unmodified; no register is inserted in the command path.
- **Accepted command.** When `io_cmd_v_o & io_cmd_yumi_i`:
  - g is pushed into the ID FIFO.
  - `rr_ptr` ← (g+1) mod `num_src_p` in round-robin mode; `rr_ptr` is unused in fixed mode.
- **Response routing.** The ID FIFO holds `max_outstanding_p` entries; responses are in order.
  - With the FIFO non-empty and head = h: `src_resp_v_o[h]` = `io_resp_v_i`, `io_resp_ready_o` = `src_resp_ready_i[h]`, and `src_resp_o` = `io_resp_i`.
  - A handshake (`io_resp_v_i & io_resp_ready_o`) pops the FIFO.
- **Orphan response.** When the FIFO is empty:
  - `io_resp_ready_o` = 1, so orphan responses are drained.
  - All `src_resp_v_o` = 0.
  - Any `io_resp_v_i` sets `error_o`, which stays set until reset.
- **Counter.** `outstanding_o` increments on push and decrements on pop. A simultaneous push and pop leaves it unchanged.
- **Full FIFO.** The full check uses the registered count. A pop in the same cycle does not allow a push (no bypass).
- **Assertions** (nonsynth):
  - Grant is one-hot.
  - No push when full.
  - A source never drops `src_cmd_v_i` before yumi.

## Timing
- Command latency is 0 cycles, combinational from `src_cmd_v_i` to `io_cmd_v_o`. Response latency is 0 cycles, from `io_resp_v_i` to `src_resp_v_o`.
- Yumi path: `src_cmd_yumi_o` depends combinationally on `io_cmd_yumi_i`. `io_resp_ready_o` depends combinationally on `src_resp_ready_i`.
- The grant may change in any cycle without a yumi; the downstream port is valid/yumi, so it does not require valid stability.
- **Reset** (synchronous, edge with `reset_i` = 1):
  - ID FIFO emptied, `outstanding_o` = 0, `rr_ptr` = 0, `error_o` = 0.
  - While reset is asserted, `io_cmd_v_o`, `src_cmd_yumi_o` and `src_resp_v_o` are 0.
  - Reset mid-transaction discards in-flight IDs. A downstream response arriving after reset is treated as an orphan and sets `error_o`.

## Test plan
- **Fixed priority.** `rr_p`=0, `num_src_p`=2, both valid for 3 cycles with yumi=1 → source 0 is granted on all 3 cycles and source 1 is starved; `outstanding_o` reaches 3.
- **Round-robin.** `rr_p`=1, `num_src_p`=3, all valid, yumi=1 every cycle → grant sequence 0,1,2,0.
- **Full FIFO and same-cycle pop.** `max_outstanding_p`=4, 4 commands accepted with no responses → `io_cmd_v_o`=0 while a source is valid.
  - Then respond, and in the same cycle present a new command → the pop succeeds, no push occurs, and the count goes 4→3.
  - On the next cycle the push is accepted.
- **Ordered routing and backpressure.** Issue the sequence src1, src0, src1, then return responses 0xA, 0xB, 0xC → 0xA is delivered to src1, 0xB to src0 and 0xC to src1.
  - Holding `src_resp_ready_i[1]`=0 keeps `io_resp_ready_o`=0, and the FIFO head does not change.
- **Orphan and reset.** Response valid with the FIFO empty → `io_resp_ready_o`=1, no `src_resp_v_o`, and `error_o`=1 from the next cycle, held until reset.
  - Reset with 2 outstanding → `outstanding_o`=0 and `error_o`=0 on the cycle after reset.
